// File: rtl/run_step_counter.sv
// run_step_counter: WIDTH-bit step counter with single-step, prescaled run, speed run, load and breakpoint halt
module run_step_counter #(
    parameter int WIDTH   = 8,
    parameter int STEP_W  = 8,
    parameter int RUN_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [STEP_W-1:0] step,
    input  logic              next,
    input  logic              run,
    input  logic              speedrun,
    input  logic              mode,
    input  logic [WIDTH-1:0]  value,
    input  logic              bp_en,
    input  logic [WIDTH-1:0]  bp_value,
    output logic [WIDTH-1:0]  count,
    output logic [WIDTH-1:0]  monitor_signal,
    output logic [1:0]        state,
    output logic              adv,
    output logic              wrap,
    output logic              bp_hit
);
    localparam int PW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(RUN_DIV - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SPEED = 2'd2} state_t;

    state_t           cur, nxt;
    logic [PW-1:0]    pre, pre_d;
    logic             next_q, run_q, speedrun_q;
    logic             next_rise, run_rise, speedrun_rise;
    logic [WIDTH-1:0] step_ext;
    logic [WIDTH:0]   sum;
    logic             do_adv, do_load, halt;

    assign next_rise     = next & ~next_q;
    assign run_rise      = run & ~run_q;
    assign speedrun_rise = speedrun & ~speedrun_q;
    assign step_ext      = WIDTH'(step);
    assign sum           = {1'b0, count} + {1'b0, step_ext};
    assign state         = cur;

    // run control: stop requests beat switches, switches beat advances; a breakpoint match during a run halts on the advancing edge
    always_comb begin
        nxt     = cur;
        pre_d   = pre;
        do_adv  = 1'b0;
        do_load = 1'b0;
        case (cur)
            IDLE: begin
                if (next_rise) begin
                    do_load = mode;
                    do_adv  = ~mode & enable;
                end else if (speedrun_rise) begin
                    nxt = SPEED;
                end else if (run_rise) begin
                    nxt   = RUN;
                    pre_d = '0;
                end
            end
            RUN: begin
                if (next_rise) begin
                    nxt = IDLE;
                end else if (speedrun_rise) begin
                    nxt = SPEED;
                end else if (run_rise) begin
                    pre_d = '0;
                end else if (enable) begin
                    do_adv = pre == PRE_LAST;
                    pre_d  = do_adv ? '0 : pre + 1'b1;
                end
            end
            SPEED: begin
                if (next_rise) begin
                    nxt = IDLE;
                end else if (run_rise & ~speedrun_rise) begin
                    nxt   = RUN;
                    pre_d = '0;
                end else begin
                    do_adv = enable;
                end
            end
            default: nxt = IDLE;
        endcase
        halt = do_adv && (cur != IDLE) && bp_en && (sum[WIDTH-1:0] == bp_value);
        if (halt) nxt = IDLE;
    end

    // state, counter, event pulses and edge-detect history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur            <= IDLE;
            pre            <= '0;
            count          <= '0;
            monitor_signal <= '0;
            adv            <= 1'b0;
            wrap           <= 1'b0;
            bp_hit         <= 1'b0;
            next_q         <= 1'b0;
            run_q          <= 1'b0;
            speedrun_q     <= 1'b0;
        end else begin
            cur        <= nxt;
            pre        <= pre_d;
            adv        <= do_adv;
            wrap       <= do_adv & sum[WIDTH];
            bp_hit     <= halt;
            next_q     <= next;
            run_q      <= run;
            speedrun_q <= speedrun;
            if (do_adv | do_load) monitor_signal <= count;
            if (do_adv) count <= sum[WIDTH-1:0];
            else if (do_load) count <= value;
        end
    end
endmodule

// File: tb/tb_run_step_counter.sv
// tb_run_step_counter: vector table, directed corner sequences and a randomized run against a reference model
module tb_run_step_counter;
    localparam int W = 8;
    localparam int RUN_DIV = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] step = '0;
    logic         next = 1'b0, run = 1'b0, speedrun = 1'b0, mode = 1'b0;
    logic [W-1:0] value = '0;
    logic         bp_en = 1'b0;
    logic [W-1:0] bp_value = '0;
    logic [W-1:0] count, monitor_signal;
    logic [1:0]   state;
    logic         adv, wrap, bp_hit;

    int checks = 0;
    int errors = 0;

    run_step_counter #(.WIDTH(W), .STEP_W(W), .RUN_DIV(RUN_DIV)) dut (
        .clk(clk), .rst(rst), .enable(enable), .step(step), .next(next), .run(run),
        .speedrun(speedrun), .mode(mode), .value(value), .bp_en(bp_en), .bp_value(bp_value),
        .count(count), .monitor_signal(monitor_signal), .state(state),
        .adv(adv), .wrap(wrap), .bp_hit(bp_hit)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        {next, run, speedrun, mode, bp_en} = '0;
        enable = 1'b1;
        step = '0;
        value = '0;
        bp_value = '0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic load(input logic [W-1:0] v);
        mode = 1'b1; value = v; next = 1'b1;
        tick();
        chk("load_count", int'(count), int'(v));
        mode = 1'b0; next = 1'b0;
        tick();
    endtask

    // reference model: plain integer bookkeeping of the counter and run control
    int m_count, m_mon, m_st, m_pre;
    bit m_adv, m_wrap, m_bp, m_pn, m_pr, m_ps;

    task automatic model_reset();
        m_count = 0; m_mon = 0; m_st = 0; m_pre = 0;
        m_adv = 0; m_wrap = 0; m_bp = 0; m_pn = 0; m_pr = 0; m_ps = 0;
    endtask

    task automatic model_edge();
        bit nr, rr, sr, a, l, h;
        int nst, total;
        nr = next && !m_pn;
        rr = run && !m_pr;
        sr = speedrun && !m_ps;
        m_pn = next; m_pr = run; m_ps = speedrun;
        a = 0; l = 0; h = 0;
        nst = m_st;
        if (m_st == 0) begin
            if (nr) begin
                if (mode) l = 1;
                else if (enable) a = 1;
            end else if (sr) nst = 2;
            else if (rr) begin nst = 1; m_pre = 0; end
        end else if (nr) nst = 0;
        else if (sr && m_st == 1) nst = 2;
        else if (rr && !sr) begin nst = 1; m_pre = 0; end
        else if (enable) begin
            if (m_st == 2) a = 1;
            else begin
                m_pre++;
                if (m_pre == RUN_DIV) begin a = 1; m_pre = 0; end
            end
        end
        total = m_count + int'(step);
        if (l) begin m_mon = m_count; m_count = int'(value); end
        if (a) begin
            m_mon = m_count;
            m_count = total % MOD;
            h = (m_st != 0) && bp_en && (m_count == int'(bp_value));
        end
        m_adv = a;
        m_wrap = a && total >= MOD;
        m_bp = h;
        m_st = h ? 0 : nst;
    endtask

    typedef struct {
        logic         nx, md, en;
        logic [W-1:0] stp, val, e_cnt, e_mon;
        logic         e_adv;
    } vec_t;

    vec_t tbl[17];
    int   adv_pulses;

    initial begin
        tbl[0]  = '{1, 0, 1, 8'd1, 8'h00, 8'h01, 8'h00, 1};
        tbl[1]  = '{1, 0, 1, 8'd1, 8'h00, 8'h01, 8'h00, 0};
        tbl[2]  = '{0, 0, 1, 8'd1, 8'h00, 8'h01, 8'h00, 0};
        tbl[3]  = '{1, 0, 1, 8'd1, 8'h00, 8'h02, 8'h01, 1};
        tbl[4]  = '{1, 0, 1, 8'd1, 8'h00, 8'h02, 8'h01, 0};
        tbl[5]  = '{0, 0, 1, 8'd1, 8'h00, 8'h02, 8'h01, 0};
        tbl[6]  = '{1, 0, 1, 8'd1, 8'h00, 8'h03, 8'h02, 1};
        tbl[7]  = '{1, 0, 1, 8'd1, 8'h00, 8'h03, 8'h02, 0};
        tbl[8]  = '{0, 0, 1, 8'd1, 8'h00, 8'h03, 8'h02, 0};
        tbl[9]  = '{1, 1, 1, 8'd1, 8'h0A, 8'h0A, 8'h03, 0};
        tbl[10] = '{0, 0, 1, 8'd2, 8'h0A, 8'h0A, 8'h03, 0};
        tbl[11] = '{1, 0, 1, 8'd2, 8'h00, 8'h0C, 8'h0A, 1};
        tbl[12] = '{0, 0, 1, 8'd2, 8'h00, 8'h0C, 8'h0A, 0};
        tbl[13] = '{1, 0, 0, 8'd2, 8'h00, 8'h0C, 8'h0A, 0};
        tbl[14] = '{0, 0, 1, 8'd2, 8'h00, 8'h0C, 8'h0A, 0};
        tbl[15] = '{1, 1, 0, 8'd2, 8'h55, 8'h55, 8'h0C, 0};
        tbl[16] = '{0, 0, 1, 8'd2, 8'h55, 8'h55, 8'h0C, 0};

        // reset state observed while reset is held
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_mon", int'(monitor_signal), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_pulses", int'({adv, wrap, bp_hit}), 0);
        do_reset();

        // single steps and loads from the vector table
        adv_pulses = 0;
        for (int i = 0; i < 17; i++) begin
            next = tbl[i].nx; mode = tbl[i].md; enable = tbl[i].en;
            step = tbl[i].stp; value = tbl[i].val;
            tick();
            chk($sformatf("vec%0d_count", i), int'(count), int'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_mon", i), int'(monitor_signal), int'(tbl[i].e_mon));
            chk($sformatf("vec%0d_adv", i), int'(adv), int'(tbl[i].e_adv));
            chk($sformatf("vec%0d_state", i), int'(state), 0);
            if (i < 9 && adv) adv_pulses++;
        end
        chk("three_step_pulses", adv_pulses, 3);

        // prescaled run, enable freeze mid-prescale, stop by next
        do_reset();
        step = 8'd1; run = 1'b1;
        tick();
        chk("run_enter_state", int'(state), 1);
        chk("run_enter_count", int'(count), 0);
        run = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("run_wait_count", int'(count), k);
            end
            tick();
            chk("run_adv_count", int'(count), k + 1);
            chk("run_adv_pulse", int'(adv), 1);
        end
        tick(); tick();
        enable = 1'b0;
        repeat (6) begin
            tick();
            chk("freeze_count", int'(count), 2);
            chk("freeze_adv", int'(adv), 0);
        end
        enable = 1'b1;
        tick();
        chk("resume_hold", int'(count), 2);
        tick();
        chk("resume_adv", int'(count), 3);
        next = 1'b1;
        tick();
        chk("run_stop_state", int'(state), 0);
        chk("run_stop_adv", int'(adv), 0);
        next = 1'b0;
        repeat (5) tick();
        chk("run_stopped_count", int'(count), 3);

        // speed run with carry out of the top bit
        do_reset();
        load(8'hFE);
        step = 8'd3; speedrun = 1'b1;
        tick();
        chk("speed_enter_state", int'(state), 2);
        chk("speed_enter_count", int'(count), 8'hFE);
        tick();
        chk("wrap_count", int'(count), 8'h01);
        chk("wrap_pulse", int'(wrap), 1);
        chk("wrap_mon", int'(monitor_signal), 8'hFE);
        tick();
        chk("wrap_next_count", int'(count), 8'h04);
        chk("wrap_clear", int'(wrap), 0);
        next = 1'b1;
        tick();
        chk("speed_stop_state", int'(state), 0);
        chk("speed_stop_count", int'(count), 8'h04);
        next = 1'b0; speedrun = 1'b0;

        // breakpoint halt, restart on the breakpoint, single step onto breakpoint
        do_reset();
        load(8'h0C);
        bp_en = 1'b1; bp_value = 8'h10; step = 8'd2; speedrun = 1'b1;
        tick();
        chk("bp_enter_state", int'(state), 2);
        tick();
        chk("bp_pre_count", int'(count), 8'h0E);
        chk("bp_pre_hit", int'(bp_hit), 0);
        tick();
        chk("bp_count", int'(count), 8'h10);
        chk("bp_state", int'(state), 0);
        chk("bp_hit", int'(bp_hit), 1);
        tick();
        chk("bp_hold_count", int'(count), 8'h10);
        chk("bp_hit_clear", int'(bp_hit), 0);
        speedrun = 1'b0;
        tick();
        speedrun = 1'b1;
        tick();
        chk("bp_restart_state", int'(state), 2);
        tick();
        chk("bp_leave_count", int'(count), 8'h12);
        chk("bp_leave_state", int'(state), 2);
        next = 1'b1;
        tick();
        next = 1'b0; speedrun = 1'b0; bp_value = 8'h14;
        tick();
        next = 1'b1;
        tick();
        chk("bp_step_count", int'(count), 8'h14);
        chk("bp_step_nohit", int'(bp_hit), 0);
        chk("bp_step_state", int'(state), 0);
        next = 1'b0;

        // asynchronous reset mid speed run, next held across release
        do_reset();
        step = 8'd2; speedrun = 1'b1;
        tick(); tick(); tick();
        chk("pre_async_state", int'(state), 2);
        next = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_state", int'(state), 0);
        chk("async_mon", int'(monitor_signal), 0);
        tick();
        chk("async_held", int'(count), 0);
        #3 rst = 1'b1;
        tick();
        chk("release_count", int'(count), 2);
        chk("release_adv", int'(adv), 1);
        chk("release_state", int'(state), 0);
        tick();
        chk("release_once", int'(count), 2);

        // randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            next = ($urandom_range(0, 7) == 0);
            run = ($urandom_range(0, 11) == 0);
            speedrun = ($urandom_range(0, 15) == 0);
            mode = ($urandom_range(0, 3) == 0);
            enable = ($urandom_range(0, 4) != 0);
            step = ($urandom_range(0, 9) == 0) ? W'($urandom) : W'($urandom_range(0, 3));
            value = W'($urandom);
            bp_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) bp_value = W'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                model_reset();
                #1;
                chk("rnd_async_count", int'(count), 0);
                chk("rnd_async_state", int'(state), 0);
                #1 rst = 1'b1;
            end
            tick();
            model_edge();
            chk("rnd_count", int'(count), m_count);
            chk("rnd_mon", int'(monitor_signal), m_mon);
            chk("rnd_state", int'(state), m_st);
            chk("rnd_adv", int'(adv), int'(m_adv));
            chk("rnd_wrap", int'(wrap), int'(m_wrap));
            chk("rnd_bp_hit", int'(bp_hit), int'(m_bp));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
